data_mem_bridge: RTL and testbench

- Sits directly downstream of the CPU core's MEM-stage data-memory port (ce/we/addr/sel/wdata out, rdata in).
- Converts that single-cycle port into a registered req/ack bus toward an external variable-latency data memory.
- Raises a stall request to the pipeline controller until each access completes; the core's MEM stage holds its outputs while the stall is asserted.

---
 rtl/data_mem_bridge_if.sv | 45 ++++
 rtl/data_mem_bridge.sv | 141 ++++++++++++++
 tb/tb_data_mem_bridge.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_if.sv
// rtl/data_mem_bridge_if.sv - req/ack data-memory bus between the bridge and the external memory
//
// Purpose : groups the registered request side and the response side of the
//           variable-latency data-memory bus.
// Signals : bus_req_o    request, held high until bus_ack_i
//           bus_we_o     1 = write, 0 = read
//           bus_addr_o   byte address
//           bus_sel_o    byte lane enables (DATA_W/8)
//           bus_wdata_o  write data
//           bus_rdata_i  read data, valid with bus_ack_i
//           bus_ack_i    one-cycle completion pulse
// Modports: master = bridge side, slave = memory side.

interface data_mem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  bus_req_o;
   logic                  bus_we_o;
   logic [ADDR_W-1:0]     bus_addr_o;
   logic [DATA_W/8-1:0]   bus_sel_o;
   logic [DATA_W-1:0]     bus_wdata_o;
   logic [DATA_W-1:0]     bus_rdata_i;
   logic                  bus_ack_i;

   modport master (
      output bus_req_o,
      output bus_we_o,
      output bus_addr_o,
      output bus_sel_o,
      output bus_wdata_o,
      input  bus_rdata_i,
      input  bus_ack_i
   );

   modport slave (
      input  bus_req_o,
      input  bus_we_o,
      input  bus_addr_o,
      input  bus_sel_o,
      input  bus_wdata_o,
      output bus_rdata_i,
      output bus_ack_i
   );
endinterface

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - MEM-stage data port to registered req/ack memory bus bridge
//
// Purpose : turns the core's single-cycle MEM-stage data port into a registered
//           req/ack access on an external variable-latency memory, stalling the
//           pipeline until the access completes.
// Ports   : clk, rst       clock, synchronous active-high reset
//           cpu_ce_i       access valid from the MEM stage
//           cpu_we_i       1 = write, 0 = read
//           cpu_addr_i     byte address
//           cpu_sel_i      byte lane enables
//           cpu_data_i     write data
//           cpu_data_o     raw read word returned to the MEM stage
//           stallreq_o     stall request to the pipeline controller
//           bus            data_mem_bridge_if.master, memory bus
//           bus_err_o      sticky timeout flag
// Option  : MEM_BUS_TIMEOUT_EN - abort a request after TIMEOUT REQ cycles
//           without ack; without it REQ waits forever and bus_err_o is 0.

module data_mem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_ce_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_W-1:0]     cpu_addr_i,
   input  logic [DATA_W/8-1:0]   cpu_sel_i,
   input  logic [DATA_W-1:0]     cpu_data_i,
   output logic [DATA_W-1:0]     cpu_data_o,
   output logic                  stallreq_o,
   data_mem_bridge_if.master     bus,
   output logic                  bus_err_o
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("data_mem_bridge: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             err_q;

   assign bus_err_o = err_q;
`else
   assign bus_err_o = 1'b0;
`endif

   // The stall has to be raised in the very cycle the access appears, so it
   // cannot be registered. DONE deliberately drops it: the MEM stage still
   // presents the finished access there and advances at the end of the cycle.
   always_comb begin
      stallreq_o = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    stallreq_o = cpu_ce_i;
            REQ:     stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.bus_req_o   <= 1'b0;
         bus.bus_we_o    <= 1'b0;
         bus.bus_addr_o  <= '0;
         bus.bus_sel_o   <= '0;
         bus.bus_wdata_o <= '0;
         cpu_data_o      <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
         tmo_cnt         <= '0;
         err_q           <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cpu_ce_i) begin
                  bus.bus_req_o   <= 1'b1;
                  bus.bus_we_o    <= cpu_we_i;
                  bus.bus_addr_o  <= cpu_addr_i;
                  bus.bus_sel_o   <= cpu_sel_i;
                  bus.bus_wdata_o <= cpu_data_i;
                  state           <= REQ;
`ifdef MEM_BUS_TIMEOUT_EN
                  tmo_cnt         <= '0;
`endif
               end
            end

            // Completion is judged on the captured bus_we_o, not cpu_we_i,
            // so a flush that changes the cpu inputs mid-access is harmless.
            REQ: begin
               if (bus.bus_ack_i) begin
                  if (!bus.bus_we_o) begin
                     cpu_data_o <= bus.bus_rdata_i;
                  end
                  bus.bus_req_o <= 1'b0;
                  state         <= DONE;
               end
`ifdef MEM_BUS_TIMEOUT_EN
               // The counter holds the number of ack-less REQ cycles already
               // spent, so seeing TIMEOUT-1 here means this is the last one.
               else if (tmo_cnt == CNT_LAST) begin
                  bus.bus_req_o <= 1'b0;
                  cpu_data_o    <= '0;
                  err_q         <= 1'b1;
                  state         <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end

            // The finished access is still on cpu_*; leaving for IDLE without
            // looking at cpu_ce_i is what prevents a duplicate request.
            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - self-checking bench for data_mem_bridge

module tb_data_mem_bridge;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [3:0]  cpu_sel;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        stallreq;
   logic        bus_err;

   data_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

   data_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_ce_i   (cpu_ce),
      .cpu_we_i   (cpu_we),
      .cpu_addr_i (cpu_addr),
      .cpu_sel_i  (cpu_sel),
      .cpu_data_i (cpu_wdata),
      .cpu_data_o (cpu_rdata),
      .stallreq_o (stallreq),
      .bus        (bus_if.master),
      .bus_err_o  (bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Cycle number: cycle c is the clock period that starts at the c-th rising edge.
   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Current access as a timeline: the access is seen in cycle m_s, occupies
   // m_nreq request cycles s+1..s+m_nreq, and finishes in cycle s+m_nreq+1.
   int          m_s      = 0;
   int          m_nreq   = 0;
   bit          m_active = 1'b0;
   bit          m_abort  = 1'b0;
   logic        m_we;
   logic [31:0] m_addr;
   logic [3:0]  m_sel;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic [31:0] exp_data;
   logic        exp_err;
   bit          model_ok = 1'b0;
   int          stall_cnt = 0;
   int          req_cnt   = 0;

   // Memory responder: pulses ack in the scheduled cycle, garbage otherwise.
   int          ack_cyc  = -1;
   logic [31:0] ack_data = '0;
   initial begin
      bus_if.bus_ack_i   = 1'b0;
      bus_if.bus_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.bus_ack_i   = (cyc == ack_cyc);
         bus_if.bus_rdata_i = (cyc == ack_cyc) ? ack_data : (32'hDEAD_0000 | 32'(cyc));
      end
   end

   always @(negedge clk) begin
      bit in_req;
      bit e_stall;
      if (rst_q) begin
         exp_data = '0;
         exp_err  = 1'b0;
         m_active = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok && m_active && cyc == m_s + m_nreq + 1) begin
         if (m_abort) begin
            exp_data = '0;
            exp_err  = 1'b1;
         end else if (!m_we) begin
            exp_data = m_rdata;
         end
      end
      if (model_ok) begin
         in_req  = m_active && cyc >= m_s + 1 && cyc <= m_s + m_nreq;
         e_stall = !rst && m_active && cyc >= m_s && cyc <= m_s + m_nreq;
         chk("stallreq", 32'(stallreq), 32'(e_stall));
         chk("bus_req", 32'(bus_if.bus_req_o), 32'(in_req));
         chk("cpu_data", cpu_rdata, exp_data);
         chk("bus_err", 32'(bus_err), 32'(exp_err));
         if (in_req) begin
            chk("bus_we", 32'(bus_if.bus_we_o), 32'(m_we));
            chk("bus_addr", bus_if.bus_addr_o, m_addr);
            chk("bus_sel", 32'(bus_if.bus_sel_o), 32'(m_sel));
            chk("bus_wdata", bus_if.bus_wdata_o, m_wdata);
         end
         if (rst_q) begin
            chk("rst_addr", bus_if.bus_addr_o, 32'h0);
            chk("rst_sel", 32'(bus_if.bus_sel_o), 32'h0);
            chk("rst_wdata", bus_if.bus_wdata_o, 32'h0);
            chk("rst_we", 32'(bus_if.bus_we_o), 32'h0);
         end
         if (stallreq) stall_cnt++;
         if (bus_if.bus_req_o) req_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Must be called in a cycle where the bridge is idle.
   task automatic start_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input bit abort);
      cpu_ce    = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_sel   = sel;
      cpu_wdata = wdata;
      m_s       = cyc;
      m_we      = we;
      m_addr    = addr;
      m_sel     = sel;
      m_wdata   = wdata;
      m_rdata   = rdata;
      m_nreq    = abort ? TMO : waits + 1;
      m_abort   = abort;
      m_active  = 1'b1;
      ack_cyc   = abort ? -1 : cyc + 1 + waits;
      ack_data  = rdata;
      stall_cnt = 0;
      req_cnt   = 0;
   endtask

   // Returns in the completion cycle with the access still on the cpu inputs.
   task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int waits, input bit abort);
      start_access(we, addr, sel, wdata, rdata, waits, abort);
      repeat (m_nreq + 1) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cpu_ce    = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 32'h0000_0040;
      cpu_sel   = 4'hF;
      cpu_wdata = 32'h0;

      // Reset held two cycles with an access pending.
      step();
      chk("rst_stall", 32'(stallreq), 32'h0);
      step();
      rst    = 1'b0;
      cpu_ce = 1'b0;
      chk("rst_req_lit", 32'(bus_if.bus_req_o), 32'h0);
      chk("rst_data_lit", cpu_rdata, 32'h0);
      step();
      step();
      chk("idle_req_lit", 32'(bus_if.bus_req_o), 32'h0);

      // Read, zero wait states.
      run_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h1234_5678, 0, 1'b0);
      chk("rd0_data_lit", cpu_rdata, 32'h1234_5678);
      chk("rd0_done_stall_lit", 32'(stallreq), 32'h0);
      step();
      cpu_ce = 1'b0;
      chk("rd0_stall_cycles", 32'(stall_cnt), 32'd2);
      chk("rd0_req_cycles", 32'(req_cnt), 32'd1);
      step();

      // Write, three wait states.
      run_access(1'b1, 32'h0000_0020, 4'b0011, 32'hAABB_CCDD, 32'h5555_5555, 3, 1'b0);
      chk("wr3_data_lit", cpu_rdata, 32'h1234_5678);
      step();
      cpu_ce = 1'b0;
      chk("wr3_stall_cycles", 32'(stall_cnt), 32'd5);
      chk("wr3_req_cycles", 32'(req_cnt), 32'd4);
      step();

      // Back-to-back read then write; the write appears right after DONE.
      run_access(1'b0, 32'h0000_0030, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
      step();
      chk("b2b_rd_req_cycles", 32'(req_cnt), 32'd2);
      chk("b2b_rd_stall_cycles", 32'(stall_cnt), 32'd3);
      chk("b2b_gap_lit", 32'(bus_if.bus_req_o), 32'h0);
      run_access(1'b1, 32'h0000_0034, 4'b1100, 32'h0102_0304, 32'h7777_7777, 0, 1'b0);
      step();
      cpu_ce = 1'b0;
      chk("b2b_wr_req_cycles", 32'(req_cnt), 32'd1);
      chk("b2b_data_lit", cpu_rdata, 32'hCAFE_F00D);
      step();

      // Reset in the second request cycle; the late ack must be ignored.
      start_access(1'b0, 32'h0000_0050, 4'hF, 32'h0, 32'h9999_AAAA, 4, 1'b0);
      step();
      step();
      rst    = 1'b1;
      cpu_ce = 1'b0;
      step();
      rst = 1'b0;
      chk("midrst_req_lit", 32'(bus_if.bus_req_o), 32'h0);
      chk("midrst_data_lit", cpu_rdata, 32'h0);
      repeat (4) step();
      chk("midrst_lateack_req_lit", 32'(bus_if.bus_req_o), 32'h0);
      chk("midrst_lateack_data_lit", cpu_rdata, 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
      // No ack: abort after TMO request cycles.
      run_access(1'b0, 32'h0000_0060, 4'hF, 32'h0, 32'h0, 0, 1'b1);
      chk("tmo_err_lit", 32'(bus_err), 32'h1);
      chk("tmo_data_lit", cpu_rdata, 32'h0);
      step();
      cpu_ce = 1'b0;
      chk("tmo_req_cycles", 32'(req_cnt), 32'(TMO));
      step();
      step();
      chk("tmo_err_held_lit", 32'(bus_err), 32'h1);
      // Ack in the last allowed cycle wins.
      run_access(1'b0, 32'h0000_0064, 4'hF, 32'h0, 32'h0BAD_BEEF, TMO - 1, 1'b0);
      chk("tmo_edge_data_lit", cpu_rdata, 32'h0BAD_BEEF);
      step();
      cpu_ce = 1'b0;
      step();
      chk("tmo_err_after_lit", 32'(bus_err), 32'h1);
`else
      chk("no_tmo_err_lit", 32'(bus_err), 32'h0);
`endif

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
